// File: rtl/regfile_sb.sv
// Two-read/one-write register file with per-register busy scoreboard and pending count.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to reads and masks the hazard.
module regfile_sb #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] d,
  input  logic             asel,
  input  logic [AW-1:0]    aaddr,
  input  logic             bsel,
  input  logic [AW-1:0]    baddr,
  output logic [WIDTH-1:0] qabus,
  output logic [WIDTH-1:0] qbbus,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  output logic             hazard_a,
  output logic             hazard_b,
  output logic [AW:0]      busy_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, set_vec, clr_vec;
  logic             wr_ok, iss_ok, rise, fall;
  logic             fwd_a, fwd_b;

  assign wr_ok  = wen && (waddr != '0);
  assign iss_ok = issue_en && (issue_addr != '0);

  // r0 is never written, so it reads back its reset value of zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= d;
    end
  end

  // set wins over clear so a re-issued register stays owned by the newer producer
  assign set_vec = iss_ok ? (DEPTH'(1) << issue_addr) : '0;
  assign clr_vec = wr_ok  ? (DEPTH'(1) << waddr)      : '0;

  assign rise = iss_ok && !busy[issue_addr];
  assign fall = wr_ok && busy[waddr] && !(iss_ok && (issue_addr == waddr));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= (busy & ~clr_vec) | set_vec;
      busy_cnt <= busy_cnt + {{AW{1'b0}}, rise} - {{AW{1'b0}}, fall};
    end
  end

`ifdef REGFILE_BYPASS_EN
  // forwarding is gated by reset so reads stay zero while reset is held
  assign fwd_a = reset_n && wr_ok && (waddr == aaddr);
  assign fwd_b = reset_n && wr_ok && (waddr == baddr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    qabus = '0;
    qbbus = '0;
    if (asel) qabus = fwd_a ? d : mem[aaddr];
    if (bsel) qbbus = fwd_b ? d : mem[baddr];
  end

  assign hazard_a = asel && busy[aaddr] && !fwd_a;
  assign hazard_b = bsel && busy[baddr] && !fwd_b;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_sb;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wen, asel, bsel, issue_en;
  logic [AW-1:0]    waddr, aaddr, baddr, issue_addr;
  logic [WIDTH-1:0] d, qabus, qbbus;
  logic             hazard_a, hazard_b;
  logic [AW:0]      busy_cnt;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] qa, qb;
    logic             ha, hb;
    logic [AW:0]      cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .wen(wen), .waddr(waddr), .d(d),
    .asel(asel), .aaddr(aaddr), .bsel(bsel), .baddr(baddr),
    .qabus(qabus), .qbbus(qbbus), .issue_en(issue_en), .issue_addr(issue_addr),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // monitor: outputs are combinational or settled registers by the falling edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      tests++;
      if (qabus !== e.qa || qbbus !== e.qb || hazard_a !== e.ha ||
          hazard_b !== e.hb || busy_cnt !== e.cnt) begin
        fails++;
        $display("FAIL %s: got qa=%h qb=%h ha=%b hb=%b cnt=%0d, want qa=%h qb=%h ha=%b hb=%b cnt=%0d",
                 e.name, qabus, qbbus, hazard_a, hazard_b, busy_cnt,
                 e.qa, e.qb, e.ha, e.hb, e.cnt);
      end
    end
  end

  task automatic drive(input logic we, input int wa, input logic [WIDTH-1:0] wd,
                       input logic as, input int aa, input logic bs, input int ba,
                       input logic ie, input int ia);
    wen = we; waddr = AW'(wa); d = wd;
    asel = as; aaddr = AW'(aa); bsel = bs; baddr = AW'(ba);
    issue_en = ie; issue_addr = AW'(ia);
  endtask

  task automatic expect_out(input string n, input logic [WIDTH-1:0] qa, input logic [WIDTH-1:0] qb,
                            input logic ha, input logic hb, input int cnt);
    exp_t e;
    e.name = n; e.qa = qa; e.qb = qb; e.ha = ha; e.hb = hb; e.cnt = (AW+1)'(cnt);
    sb_q.push_back(e);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    next();
    // held reset: everything zero
    drive(0, 0, '0, 1, 5, 1, 7, 0, 0);
    expect_out("reset", '0, '0, 0, 0, 0);
    next();
    reset_n = 1'b1;

    drive(1, 5, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0);
    expect_out("wr_r5_same", BYP ? 32'hDEADBEEF : '0, '0, 0, 0, 0);
    next();
    drive(0, 0, '0, 1, 5, 1, 0, 0, 0);
    expect_out("r5_r0", 32'hDEADBEEF, '0, 0, 0, 0);
    next();

    drive(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 1, 0);
    expect_out("wr_r0", '0, '0, 0, 0, 0);
    next();
    drive(0, 0, '0, 1, 0, 1, 0, 0, 0);
    expect_out("r0_after", '0, '0, 0, 0, 0);
    next();

    drive(0, 0, '0, 0, 0, 0, 0, 1, 3);
    next();
    drive(0, 0, '0, 1, 3, 0, 0, 1, 7);
    expect_out("iss_r7", '0, '0, 1, 0, 1);
    next();
    drive(0, 0, '0, 1, 3, 1, 7, 0, 0);
    expect_out("busy2", '0, '0, 1, 1, 2);
    next();
    drive(1, 3, 32'h33, 1, 3, 1, 7, 0, 0);
    expect_out("wr_r3_same", BYP ? 32'h33 : '0, '0, !BYP, 1, 2);
    next();
    drive(0, 0, '0, 1, 3, 0, 0, 0, 0);
    expect_out("wr_r3", 32'h33, '0, 0, 0, 1);
    next();

    drive(0, 0, '0, 0, 0, 1, 4, 1, 4);
    expect_out("iss_r4", '0, '0, 0, 0, 1);
    next();
    drive(1, 4, 32'h44, 1, 4, 0, 0, 1, 4);
    expect_out("r4_both_same", BYP ? 32'h44 : '0, '0, !BYP, 0, 2);
    next();
    drive(0, 0, '0, 1, 4, 0, 0, 0, 0);
    expect_out("r4_stay", 32'h44, '0, 1, 0, 2);
    next();

    drive(1, 9, 32'hAAAA5555, 0, 0, 0, 0, 0, 0);
    next();
    drive(1, 9, 32'h12345678, 1, 9, 0, 0, 0, 0);
    expect_out("r9_same", BYP ? 32'h12345678 : 32'hAAAA5555, '0, 0, 0, 2);
    next();
    drive(0, 0, '0, 1, 9, 0, 0, 0, 0);
    expect_out("r9_after", 32'h12345678, '0, 0, 0, 2);
    next();
    drive(0, 0, '0, 0, 5, 0, 4, 0, 0);
    expect_out("disabled", '0, '0, 0, 0, 2);
    next();

    for (int i = 1; i < DEPTH; i++) begin
      drive(0, 0, '0, 0, 0, 0, 0, 1, i);
      next();
    end
    drive(0, 0, '0, 1, 31, 1, 1, 1, 5);
    expect_out("full", '0, '0, 1, 1, 31);
    next();
    drive(0, 0, '0, 1, 9, 0, 0, 0, 0);
    expect_out("cnt_max", 32'h12345678, '0, 1, 0, 31);
    next();

    // reset asserted between edges must clear state at once
    reset_n = 1'b0;
    drive(0, 0, '0, 1, 5, 1, 9, 0, 0);
    expect_out("reset_mid", '0, '0, 0, 0, 0);
    next();
    reset_n = 1'b1;
    drive(1, 6, 32'h66, 1, 5, 0, 0, 1, 2);
    expect_out("post_rst_same", '0, '0, 0, 0, 0);
    next();
    drive(0, 0, '0, 1, 6, 1, 2, 0, 0);
    expect_out("post_rst", 32'h66, '0, 0, 1, 1);
    next();

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
